// File: rtl/sdram_read_arbiter.sv
// Two-port round-robin read arbiter in front of a pipelined Avalon-MM SDRAM read master.
// A tag FIFO records which port issued each accepted read, so returned words reach the right port.
module sdram_read_arbiter #(
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 32,
    parameter int MAX_PENDING = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_read_n,
    input  logic [ADDR_W-1:0] p0_address,
    output logic              p0_accept_n,
    output logic [DATA_W-1:0] p0_data,
    output logic              p0_data_ready_n,
    input  logic              p1_read_n,
    input  logic [ADDR_W-1:0] p1_address,
    output logic              p1_accept_n,
    output logic [DATA_W-1:0] p1_data,
    output logic              p1_data_ready_n,
    output logic [ADDR_W-1:0] avm_m0_address,
    output logic              avm_m0_read_n,
    input  logic [DATA_W-1:0] avm_m0_readdata,
    input  logic              avm_m0_waitrequest,
    input  logic              avm_m0_readdatavalid
);
    localparam int PW = $clog2(MAX_PENDING);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              grant;
    logic              accept;
    logic              pop;
    logic              req0;
    logic              req1;
    logic              pick;
    logic              winner;
    logic              last_grant;
    logic              head;
    logic [CW-1:0]     count;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [MAX_PENDING-1:0] tag_mem;

    // Handshakes: a port holds read_n low with a stable address until it sees accept_n low
    // at a rising edge; a command is taken by the controller in an ISSUE cycle with waitrequest low.
    assign req0   = ~p0_read_n;
    assign req1   = ~p1_read_n;
    assign pick   = (req0 && req1) ? ~last_grant : req1;
    assign accept = (state == ISSUE) && !avm_m0_waitrequest;
    assign pop    = avm_m0_readdatavalid && (count != '0);
    assign head   = tag_mem[rd_ptr];

    assign p0_accept_n = ~(accept && !winner);
    assign p1_accept_n = ~(accept && winner);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if ((count < CW'(MAX_PENDING)) && (req0 || req1)) begin
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (accept) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // last_grant resets to port 1 so that port 0 is preferred first.
    always_ff @(posedge clk) begin
        if (reset) begin
            avm_m0_address <= '0;
            avm_m0_read_n  <= 1'b1;
            winner         <= 1'b0;
            last_grant     <= 1'b1;
        end else begin
            if (grant) begin
                avm_m0_address <= pick ? p1_address : p0_address;
                winner         <= pick;
                avm_m0_read_n  <= 1'b0;
            end
            if (accept) begin
                avm_m0_read_n <= 1'b1;
                last_grant    <= winner;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_mem <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (accept) begin
                tag_mem[wr_ptr] <= winner;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (accept && !pop)      count <= count + CW'(1);
            else if (pop && !accept) count <= count - CW'(1);
        end
    end

    // A valid with nothing outstanding is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            p0_data         <= '0;
            p1_data         <= '0;
            p0_data_ready_n <= 1'b1;
            p1_data_ready_n <= 1'b1;
        end else begin
            p0_data_ready_n <= 1'b1;
            p1_data_ready_n <= 1'b1;
            if (pop) begin
                if (head) begin
                    p1_data         <= avm_m0_readdata;
                    p1_data_ready_n <= 1'b0;
                end else begin
                    p0_data         <= avm_m0_readdata;
                    p0_data_ready_n <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Directed bench for sdram_read_arbiter: inputs change 1 time unit after a rising edge,
// outputs are sampled on the falling edge.
module tb_sdram_read_arbiter;
    localparam int ADDR_W = 25;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              p0_read_n = 1'b1;
    logic [ADDR_W-1:0] p0_address = '0;
    logic              p0_accept_n;
    logic [DATA_W-1:0] p0_data;
    logic              p0_data_ready_n;
    logic              p1_read_n = 1'b1;
    logic [ADDR_W-1:0] p1_address = '0;
    logic              p1_accept_n;
    logic [DATA_W-1:0] p1_data;
    logic              p1_data_ready_n;
    logic [ADDR_W-1:0] avm_m0_address;
    logic              avm_m0_read_n;
    logic [DATA_W-1:0] avm_m0_readdata = '0;
    logic              avm_m0_waitrequest = 1'b0;
    logic              avm_m0_readdatavalid = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    sdram_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(4)) dut (
        .clk(clk), .reset(reset),
        .p0_read_n(p0_read_n), .p0_address(p0_address), .p0_accept_n(p0_accept_n),
        .p0_data(p0_data), .p0_data_ready_n(p0_data_ready_n),
        .p1_read_n(p1_read_n), .p1_address(p1_address), .p1_accept_n(p1_accept_n),
        .p1_data(p1_data), .p1_data_ready_n(p1_data_ready_n),
        .avm_m0_address(avm_m0_address), .avm_m0_read_n(avm_m0_read_n),
        .avm_m0_readdata(avm_m0_readdata), .avm_m0_waitrequest(avm_m0_waitrequest),
        .avm_m0_readdatavalid(avm_m0_readdatavalid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        reset = 1'b1;
        p0_read_n = 1'b1;
        p1_read_n = 1'b1;
        avm_m0_waitrequest = 1'b0;
        avm_m0_readdatavalid = 1'b0;
        avm_m0_readdata = '0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++; if (avm_m0_read_n !== 1'b1) $display("FAIL reset_read_n got %b want 1", avm_m0_read_n); else n_pass++;
        n_checks++; if (avm_m0_address !== '0) $display("FAIL reset_address got %h want 0", avm_m0_address); else n_pass++;
        n_checks++; if ({p0_accept_n, p1_accept_n} !== 2'b11) $display("FAIL reset_accept got %b want 11", {p0_accept_n, p1_accept_n}); else n_pass++;
        n_checks++; if ({p0_data_ready_n, p1_data_ready_n} !== 2'b11) $display("FAIL reset_ready got %b want 11", {p0_data_ready_n, p1_data_ready_n}); else n_pass++;
        n_checks++; if (p0_data !== '0 || p1_data !== '0) $display("FAIL reset_data got %h/%h want 0/0", p0_data, p1_data); else n_pass++;
    endtask

    task automatic test_single_read();
        do_reset();
        cyc();
        p0_read_n = 1'b0;
        p0_address = 25'h0001234;
        @(negedge clk);
        n_checks++; if (avm_m0_read_n !== 1'b1) $display("FAIL single_latency read_n got %b want 1", avm_m0_read_n); else n_pass++;
        cyc();
        @(negedge clk);
        n_checks++; if (avm_m0_read_n !== 1'b0) $display("FAIL single_cmd read_n got %b want 0", avm_m0_read_n); else n_pass++;
        n_checks++; if (avm_m0_address !== 25'h0001234) $display("FAIL single_cmd address got %h want 0001234", avm_m0_address); else n_pass++;
        n_checks++; if ({p0_accept_n, p1_accept_n} !== 2'b01) $display("FAIL single_accept got %b want 01", {p0_accept_n, p1_accept_n}); else n_pass++;
        cyc();
        p0_read_n = 1'b1;
        @(negedge clk);
        n_checks++; if (avm_m0_read_n !== 1'b1 || p0_accept_n !== 1'b1) $display("FAIL single_one_cycle read_n/accept got %b%b want 11", avm_m0_read_n, p0_accept_n); else n_pass++;
        cyc();
        cyc();
        avm_m0_readdatavalid = 1'b1;
        avm_m0_readdata = 32'hDEADBEEF;
        @(negedge clk);
        n_checks++; if (p0_data_ready_n !== 1'b1) $display("FAIL single_data_early ready got %b want 1", p0_data_ready_n); else n_pass++;
        cyc();
        avm_m0_readdatavalid = 1'b0;
        @(negedge clk);
        n_checks++; if (p0_data_ready_n !== 1'b0 || p0_data !== 32'hDEADBEEF) $display("FAIL single_data got ready=%b data=%h want 0/deadbeef", p0_data_ready_n, p0_data); else n_pass++;
        n_checks++; if (p1_data_ready_n !== 1'b1 || p1_data !== '0) $display("FAIL single_p1_idle got ready=%b data=%h want 1/0", p1_data_ready_n, p1_data); else n_pass++;
        cyc();
        @(negedge clk);
        n_checks++; if (p0_data_ready_n !== 1'b1) $display("FAIL single_pulse_width ready got %b want 1", p0_data_ready_n); else n_pass++;
    endtask

    task automatic test_round_robin_and_limit();
        logic exp_port;
        cyc();
        reset = 1'b1;
        avm_m0_readdatavalid = 1'b0;
        avm_m0_waitrequest = 1'b0;
        p0_read_n = 1'b0;
        p1_read_n = 1'b0;
        p0_address = 25'h0000100;
        p1_address = 25'h0000200;
        cyc();
        cyc();
        reset = 1'b0;
        for (int g = 0; g < 4; g++) begin
            exp_port = g[0];
            cyc();
            @(negedge clk);
            n_checks++; if (avm_m0_read_n !== 1'b0 || avm_m0_address !== (exp_port ? 25'h0000200 : 25'h0000100))
                $display("FAIL rr_cmd%0d got read_n=%b addr=%h want 0/%h", g, avm_m0_read_n, avm_m0_address, exp_port ? 25'h0000200 : 25'h0000100); else n_pass++;
            n_checks++; if ({p0_accept_n, p1_accept_n} !== (exp_port ? 2'b10 : 2'b01))
                $display("FAIL rr_accept%0d got %b want %b", g, {p0_accept_n, p1_accept_n}, exp_port ? 2'b10 : 2'b01); else n_pass++;
            cyc();
            @(negedge clk);
            n_checks++; if (avm_m0_read_n !== 1'b1) $display("FAIL rr_bubble%0d read_n got %b want 1", g, avm_m0_read_n); else n_pass++;
        end
        for (int s = 0; s < 3; s++) begin
            cyc();
            @(negedge clk);
            n_checks++; if (avm_m0_read_n !== 1'b1) $display("FAIL limit_stall%0d read_n got %b want 1", s, avm_m0_read_n); else n_pass++;
        end
        cyc();
        avm_m0_readdatavalid = 1'b1;
        avm_m0_readdata = 32'h000055AA;
        cyc();
        avm_m0_readdatavalid = 1'b0;
        @(negedge clk);
        n_checks++; if (p0_data_ready_n !== 1'b0 || p0_data !== 32'h000055AA) $display("FAIL limit_pop got ready=%b data=%h want 0/000055aa", p0_data_ready_n, p0_data); else n_pass++;
        n_checks++; if (avm_m0_read_n !== 1'b1) $display("FAIL limit_pop_cycle read_n got %b want 1", avm_m0_read_n); else n_pass++;
        cyc();
        @(negedge clk);
        n_checks++; if (avm_m0_read_n !== 1'b0 || avm_m0_address !== 25'h0000100 || p0_accept_n !== 1'b0)
            $display("FAIL limit_resume got read_n=%b addr=%h acc0=%b want 0/0000100/0", avm_m0_read_n, avm_m0_address, p0_accept_n); else n_pass++;
        cyc();
        p0_read_n = 1'b1;
        p1_read_n = 1'b1;
    endtask

    task automatic test_waitrequest();
        do_reset();
        cyc();
        avm_m0_waitrequest = 1'b1;
        p1_read_n = 1'b0;
        p1_address = 25'h00ABCDE;
        for (int w = 0; w < 5; w++) begin
            cyc();
            @(negedge clk);
            n_checks++; if (avm_m0_read_n !== 1'b0 || avm_m0_address !== 25'h00ABCDE || {p0_accept_n, p1_accept_n} !== 2'b11)
                $display("FAIL wait_hold%0d got read_n=%b addr=%h acc=%b want 0/00abcde/11", w, avm_m0_read_n, avm_m0_address, {p0_accept_n, p1_accept_n}); else n_pass++;
        end
        cyc();
        avm_m0_waitrequest = 1'b0;
        @(negedge clk);
        n_checks++; if (avm_m0_read_n !== 1'b0 || {p0_accept_n, p1_accept_n} !== 2'b10)
            $display("FAIL wait_accept got read_n=%b acc=%b want 0/10", avm_m0_read_n, {p0_accept_n, p1_accept_n}); else n_pass++;
        cyc();
        p1_read_n = 1'b1;
        @(negedge clk);
        n_checks++; if (avm_m0_read_n !== 1'b1 || p1_accept_n !== 1'b1) $display("FAIL wait_release got read_n=%b acc1=%b want 1/1", avm_m0_read_n, p1_accept_n); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        cyc();
        p0_read_n = 1'b0; p0_address = 25'h10;
        cyc();
        @(negedge clk);
        n_checks++; if (p0_accept_n !== 1'b0) $display("FAIL b2b_acc_a got %b want 0", p0_accept_n); else n_pass++;
        cyc();
        p0_read_n = 1'b1; p1_read_n = 1'b0; p1_address = 25'h20;
        cyc();
        @(negedge clk);
        n_checks++; if (p1_accept_n !== 1'b0) $display("FAIL b2b_acc_b got %b want 0", p1_accept_n); else n_pass++;
        cyc();
        p1_read_n = 1'b1; p0_read_n = 1'b0; p0_address = 25'h30;
        cyc();
        @(negedge clk);
        n_checks++; if (p0_accept_n !== 1'b0 || avm_m0_address !== 25'h30) $display("FAIL b2b_acc_c got acc0=%b addr=%h want 0/30", p0_accept_n, avm_m0_address); else n_pass++;
        cyc();
        p0_read_n = 1'b1; p1_read_n = 1'b0; p1_address = 25'h40;
        cyc();
        avm_m0_readdatavalid = 1'b1; avm_m0_readdata = 32'hAAAA0001;
        @(negedge clk);
        n_checks++; if (p1_accept_n !== 1'b0 || avm_m0_address !== 25'h40) $display("FAIL b2b_acc_d got acc1=%b addr=%h want 0/40", p1_accept_n, avm_m0_address); else n_pass++;
        cyc();
        p1_read_n = 1'b1; avm_m0_readdata = 32'hBBBB0002;
        @(negedge clk);
        n_checks++; if (p0_data_ready_n !== 1'b0 || p0_data !== 32'hAAAA0001 || p1_data_ready_n !== 1'b1)
            $display("FAIL b2b_data_a got r0=%b d0=%h r1=%b want 0/aaaa0001/1", p0_data_ready_n, p0_data, p1_data_ready_n); else n_pass++;
        cyc();
        avm_m0_readdata = 32'hCCCC0003;
        @(negedge clk);
        n_checks++; if (p1_data_ready_n !== 1'b0 || p1_data !== 32'hBBBB0002 || p0_data_ready_n !== 1'b1 || p0_data !== 32'hAAAA0001)
            $display("FAIL b2b_data_b got r1=%b d1=%h r0=%b d0=%h want 0/bbbb0002/1/aaaa0001", p1_data_ready_n, p1_data, p0_data_ready_n, p0_data); else n_pass++;
        cyc();
        avm_m0_readdata = 32'hDDDD0004;
        @(negedge clk);
        n_checks++; if (p0_data_ready_n !== 1'b0 || p0_data !== 32'hCCCC0003 || p1_data !== 32'hBBBB0002)
            $display("FAIL b2b_data_c got r0=%b d0=%h d1=%h want 0/cccc0003/bbbb0002", p0_data_ready_n, p0_data, p1_data); else n_pass++;
        cyc();
        avm_m0_readdatavalid = 1'b0;
        @(negedge clk);
        n_checks++; if (p1_data_ready_n !== 1'b0 || p1_data !== 32'hDDDD0004 || p0_data_ready_n !== 1'b1)
            $display("FAIL b2b_data_d got r1=%b d1=%h r0=%b want 0/dddd0004/1", p1_data_ready_n, p1_data, p0_data_ready_n); else n_pass++;
        cyc();
        avm_m0_readdatavalid = 1'b1; avm_m0_readdata = 32'hEEEE0005;
        cyc();
        avm_m0_readdatavalid = 1'b0;
        @(negedge clk);
        n_checks++; if ({p0_data_ready_n, p1_data_ready_n} !== 2'b11 || p0_data !== 32'hCCCC0003 || p1_data !== 32'hDDDD0004)
            $display("FAIL b2b_stray got ready=%b d0=%h d1=%h want 11/cccc0003/dddd0004", {p0_data_ready_n, p1_data_ready_n}, p0_data, p1_data); else n_pass++;
    endtask

    task automatic test_reset_mid_flight();
        do_reset();
        cyc();
        p1_read_n = 1'b0; p1_address = 25'h50;
        cyc();
        @(negedge clk);
        n_checks++; if (p1_accept_n !== 1'b0) $display("FAIL midrst_acc_a got %b want 0", p1_accept_n); else n_pass++;
        cyc();
        p1_read_n = 1'b1; p0_read_n = 1'b0; p0_address = 25'h60;
        cyc();
        @(negedge clk);
        n_checks++; if (p0_accept_n !== 1'b0) $display("FAIL midrst_acc_b got %b want 0", p0_accept_n); else n_pass++;
        cyc();
        p0_read_n = 1'b1;
        cyc();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (avm_m0_read_n !== 1'b1 || avm_m0_address !== '0 || {p0_accept_n, p1_accept_n} !== 2'b11)
            $display("FAIL midrst_cmd got read_n=%b addr=%h acc=%b want 1/0/11", avm_m0_read_n, avm_m0_address, {p0_accept_n, p1_accept_n}); else n_pass++;
        n_checks++; if ({p0_data_ready_n, p1_data_ready_n} !== 2'b11 || p0_data !== '0 || p1_data !== '0)
            $display("FAIL midrst_rsp got ready=%b d0=%h d1=%h want 11/0/0", {p0_data_ready_n, p1_data_ready_n}, p0_data, p1_data); else n_pass++;
        cyc();
        avm_m0_readdatavalid = 1'b1; avm_m0_readdata = 32'h11;
        cyc();
        avm_m0_readdata = 32'h22;
        @(negedge clk);
        n_checks++; if ({p0_data_ready_n, p1_data_ready_n} !== 2'b11) $display("FAIL midrst_stray1 got %b want 11", {p0_data_ready_n, p1_data_ready_n}); else n_pass++;
        cyc();
        avm_m0_readdatavalid = 1'b0;
        @(negedge clk);
        n_checks++; if ({p0_data_ready_n, p1_data_ready_n} !== 2'b11 || p0_data !== '0 || p1_data !== '0)
            $display("FAIL midrst_stray2 got ready=%b d0=%h d1=%h want 11/0/0", {p0_data_ready_n, p1_data_ready_n}, p0_data, p1_data); else n_pass++;
        cyc();
        p0_read_n = 1'b0; p0_address = 25'h70;
        p1_read_n = 1'b0; p1_address = 25'h80;
        cyc();
        @(negedge clk);
        n_checks++; if (avm_m0_read_n !== 1'b0 || avm_m0_address !== 25'h70 || {p0_accept_n, p1_accept_n} !== 2'b01)
            $display("FAIL midrst_first_grant got read_n=%b addr=%h acc=%b want 0/70/01", avm_m0_read_n, avm_m0_address, {p0_accept_n, p1_accept_n}); else n_pass++;
        cyc();
        p0_read_n = 1'b1; p1_read_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin_and_limit();
        test_waitrequest();
        test_back_to_back();
        test_reset_mid_flight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sdram_read_arbiter.md
# sdram_read_arbiter

Shares the single pipelined Avalon-MM read master on the SDRAM controller between two requesters: port 0 is instruction fetch, port 1 is data load. Round-robin grant, one command in flight on the command bus, up to MAX_PENDING reads outstanding. Uses `avm_m0_readdatavalid`, so the controller's pipelining stays enabled. A tag FIFO routes each returned word to the requester that issued it.

## Interface
Parameters:
- ADDR_W, 25, address width in words
- DATA_W, 32, data width
- MAX_PENDING, 4, maximum reads accepted by the controller but not yet returned (power of two, 2..16)

Ports:
- clk  in  1  sole clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- p0_read_n  in  1  port 0 request, active-low, held until accepted
- p0_address  in  ADDR_W  port 0 address, stable while p0_read_n low
- p0_accept_n  out  1  low for one cycle when the port 0 command is taken by the controller
- p0_data  out  DATA_W  port 0 read data
- p0_data_ready_n  out  1  low for one cycle when p0_data is valid
- p1_read_n, p1_address, p1_accept_n, p1_data, p1_data_ready_n  same as port 0, for port 1
- avm_m0_address  out  ADDR_W  Avalon address
- avm_m0_read_n  out  1  Avalon read, active-low
- avm_m0_readdata  in  DATA_W  Avalon read data
- avm_m0_waitrequest  in  1  Avalon wait request
- avm_m0_readdatavalid  in  1  Avalon read data valid

## Operation
- Reset values:
  - avm_m0_read_n=1, avm_m0_address=0
  - pX_accept_n=1, pX_data_ready_n=1, pX_data=0
  - pending count=0, tag FIFO empty, round-robin pointer=port 0 preferred, state IDLE
- State IDLE:
  - Grant is eligible only when count<MAX_PENDING and at least one pX_read_n is low.
  - When one port requests, it wins.
  - When both request, the port not granted last wins; after reset, port 0 wins.
  - On grant: register the winner's address into avm_m0_address, register the winner id, drive avm_m0_read_n=0 next cycle, go to ISSUE.
- State ISSUE:
  - Hold avm_m0_address and avm_m0_read_n=0 while avm_m0_waitrequest=1.
  - In the cycle waitrequest=0, the command is accepted:
    - push the winner id into the tag FIFO;
    - drive the winner's pX_accept_n=0 (combinational from state and waitrequest);
    - update the round-robin pointer;
    - next cycle: avm_m0_read_n=1, state IDLE.
- Requester rule: deassert read_n, or present a new address, no earlier than the edge that samples accept_n=0. A request still asserted in the following IDLE cycle is a new request.
- Response path, independent of command state:
  - On avm_m0_readdatavalid=1 with the FIFO non-empty: pop the head id, register avm_m0_readdata into that port's pX_data, and drive that port's pX_data_ready_n=0 next cycle for one cycle.
  - The other port's data and ready outputs are unchanged.
- readdatavalid may coincide with waitrequest=0 in ISSUE. Push and pop happen in the same cycle and the count is unchanged.
- readdatavalid with the FIFO empty is a protocol error. It is ignored: no ready pulse, and the count stays 0.
- Count: +1 on accept, −1 on valid pop, unchanged when both occur in the same cycle. It never exceeds MAX_PENDING, because a grant requires count<MAX_PENDING and count cannot rise during ISSUE.
- Responses return in controller order. FIFO order equals issue order.
- Reset mid-transaction: all state clears at the reset edge. Any readdatavalid arriving after reset finds the FIFO empty and is dropped.

## Timing
- Command latency: request low in cycle N (IDLE, eligible) → avm_m0_read_n low in N+1.
- Accept: pX_accept_n low in the first ISSUE cycle with waitrequest=0. With zero wait, that is N+1.
- Maximum command rate: one per 2 cycles (IDLE bubble between commands).
- Data latency: readdatavalid in cycle M → pX_data valid and pX_data_ready_n low in M+1.
- Back-to-back readdatavalid cycles produce back-to-back ready pulses, possibly alternating ports.

## Test plan
- Single read, port 0, address 0x0001234, waitrequest=0, readdatavalid 3 cycles after accept with data 0xDEADBEEF:
  - avm_m0_read_n low exactly 1 cycle, p0_accept_n low that cycle;
  - p0_data=0xDEADBEEF with p0_data_ready_n low 1 cycle; p1 outputs idle.
- Both ports request continuously from reset, waitrequest=0:
  - grants alternate 0,1,0,1;
  - avm_m0_address alternates between p0_address and p1_address every 2 cycles.
- waitrequest held high 5 cycles:
  - avm_m0_address and avm_m0_read_n stay stable for all 5 cycles;
  - accept_n pulses only in cycle 6.
- MAX_PENDING=4, no readdatavalid:
  - after 4 accepts, a 5th request is not granted (avm_m0_read_n stays 1);
  - one readdatavalid → the grant proceeds the next cycle.
- Issue order p0,p1,p0, then data A,B,C with readdatavalid on consecutive cycles, the first coinciding with waitrequest=0 of a 4th command:
  - p0 gets A, p1 gets B, p0 gets C;
  - count correct (push and pop in the same cycle); 4th command tagged correctly.
- Reset asserted with 2 reads outstanding, then 2 stray readdatavalid pulses:
  - no pX_data_ready_n pulses;
  - all outputs at reset values; first post-reset grant goes to port 0.
